riscv_mc_core: RTL and testbench

Multi-cycle RV32I-subset core, the successor to the single-cycle top. Instructions execute over 3-5 states of a controller FSM, and one unified memory port serves both fetch and load/store. The memory port uses a req/ready handshake, so wait-state memories are tolerated. It reuses the existing alu, reg_file and imm_generator; the memory sits outside the core.

---
 rtl/riscv_pkg.sv | 61 ++++++
 rtl/alu.sv | 29 ++
 rtl/imm_generator.sv | 21 ++
 rtl/mc_controller.sv | 102 ++++++++++
 rtl/reg_file.sv | 30 +++
 rtl/riscv_mc_core.sv | 88 ++++++++
 tb/tb_riscv_mc_core.sv | 249 ++++++++++++++++++++++++
 7 files changed

// File: rtl/riscv_pkg.sv
// Shared types, opcodes and decode helpers for the multi-cycle RV32I-subset core.
package riscv_pkg;
  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXECUTE = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4
  } imm_src_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3, ALU_SLTU = 4'd4,
    ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR = 4'd8, ALU_AND = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    AO_HOLD = 3'd0, AO_TARGET = 3'd1, AO_ALU = 3'd2, AO_LINK = 3'd3, AO_IMM = 3'd4
  } aluout_sel_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  function automatic logic is_legal(input logic [6:0] opcode, input logic [2:0] f3);
    logic ok;
    case (opcode)
      OP_R, OP_I, OP_JAL, OP_LUI: ok = 1'b1;
      OP_LOAD, OP_STORE:          ok = (f3 == 3'b010);
      OP_BRANCH:                  ok = (f3 == 3'b000) || (f3 == 3'b001);
      default:                    ok = 1'b0;
    endcase
    return ok;
  endfunction

  // SUB exists only for register-register; bit 30 selects SRA for both forms
  function automatic alu_op_e alu_decode(input logic [6:0] opcode, input logic [2:0] f3,
                                         input logic f7b5);
    alu_op_e op;
    op = ALU_ADD;
    if ((opcode == OP_R) || (opcode == OP_I)) begin
      case (f3)
        3'b000:  op = ((opcode == OP_R) && f7b5) ? ALU_SUB : ALU_ADD;
        3'b001:  op = ALU_SLL;
        3'b010:  op = ALU_SLT;
        3'b011:  op = ALU_SLTU;
        3'b100:  op = ALU_XOR;
        3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
        3'b110:  op = ALU_OR;
        3'b111:  op = ALU_AND;
        default: op = ALU_ADD;
      endcase
    end else begin
      op = ALU_ADD;
    end
    return op;
  endfunction
endpackage

// File: rtl/alu.sv
// Combinational integer ALU.
module alu import riscv_pkg::*; #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  alu_op_e       op,
  output logic [DW-1:0] y
);
  localparam int SHW = $clog2(DW);

  // operation select
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << b[SHW-1:0];
      ALU_SLT:  y = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: y = {{(DW-1){1'b0}}, (a < b)};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> b[SHW-1:0];
      ALU_SRA:  y = $signed(a) >>> b[SHW-1:0];
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = a + b;
    endcase
  end
endmodule

// File: rtl/imm_generator.sv
// Sign-extended immediate extraction for I/S/B/U/J formats.
module imm_generator import riscv_pkg::*; #(
  parameter int DW = 32
) (
  input  logic [31:7]   instr,
  input  imm_src_e      imm_src,
  output logic [DW-1:0] imm
);
  // format select
  always_comb begin
    imm = '0;
    case (imm_src)
      IMM_I:   imm = {{(DW-12){instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{(DW-12){instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{(DW-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = DW'($signed({instr[31:12], 12'h000}));
      IMM_J:   imm = {{(DW-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end
endmodule

// File: rtl/mc_controller.sv
// Controller FSM for the multi-cycle core: sequencing, decode, mux selects and enables.
module mc_controller import riscv_pkg::*; (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [6:0]  opcode,
  input  logic [2:0]  f3,
  input  logic        f7b5,
  input  logic        mem_ready,
  input  logic        addr_misaligned,
  input  logic        target_misaligned,
  input  logic        operands_equal,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel_alu,
  output logic        ir_en,
  output logic        ab_en,
  output logic        pc_target_en,
  output logic        mdr_en,
  output logic        rf_we,
  output logic        wb_sel_mdr,
  output logic        src_b_imm,
  output aluout_sel_e aluout_sel,
  output imm_src_e    imm_src,
  output alu_op_e     alu_op,
  output logic        retire,
  output logic        trap
);
  state_e state_r, next_state_s;
  logic   taken_s, is_store_s;

  assign taken_s    = (f3 == 3'b000) ? operands_equal : !operands_equal;
  assign is_store_s = (opcode == OP_STORE);

  // state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_r <= FETCH;
    else        state_r <= next_state_s;
  end

  // next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      FETCH:   if (mem_ready) next_state_s = DECODE; else next_state_s = FETCH;
      DECODE:  if (is_legal(opcode, f3)) next_state_s = EXECUTE; else next_state_s = TRAP;
      EXECUTE: begin
        case (opcode)
          OP_LOAD, OP_STORE: next_state_s = addr_misaligned ? TRAP : MEM;
          OP_BRANCH:         next_state_s = (taken_s && target_misaligned) ? TRAP : FETCH;
          OP_JAL:            next_state_s = target_misaligned ? TRAP : WB;
          default:           next_state_s = WB;
        endcase
      end
      MEM:     if (mem_ready) next_state_s = is_store_s ? FETCH : WB; else next_state_s = MEM;
      WB:      next_state_s = FETCH;
      TRAP:    next_state_s = TRAP;
      default: next_state_s = TRAP;
    endcase
  end

  // output decode
  always_comb begin
    mem_req = 1'b0; mem_we = 1'b0; addr_sel_alu = 1'b0; ir_en = 1'b0; ab_en = 1'b0;
    pc_target_en = 1'b0; mdr_en = 1'b0; rf_we = 1'b0; wb_sel_mdr = 1'b0;
    retire = 1'b0; trap = 1'b0; aluout_sel = AO_HOLD;
    src_b_imm = (opcode != OP_R);
    alu_op    = alu_decode(opcode, f3, f7b5);
    case (opcode)
      OP_STORE:  imm_src = IMM_S;
      OP_BRANCH: imm_src = IMM_B;
      OP_JAL:    imm_src = IMM_J;
      OP_LUI:    imm_src = IMM_U;
      default:   imm_src = IMM_I;
    endcase
    case (state_r)
      FETCH:   begin mem_req = 1'b1; ir_en = mem_ready; end
      DECODE:  begin ab_en = 1'b1; aluout_sel = AO_TARGET; end
      EXECUTE: begin
        case (opcode)
          OP_R, OP_I, OP_LOAD, OP_STORE: aluout_sel = AO_ALU;
          OP_BRANCH: begin
            pc_target_en = taken_s && !target_misaligned;
            retire       = !(taken_s && target_misaligned);
          end
          OP_JAL:  begin pc_target_en = !target_misaligned; aluout_sel = AO_LINK; end
          OP_LUI:  aluout_sel = AO_IMM;
          default: aluout_sel = AO_HOLD;
        endcase
      end
      MEM: begin
        mem_req      = 1'b1;
        mem_we       = is_store_s;
        addr_sel_alu = 1'b1;
        mdr_en       = mem_ready && !is_store_s;
        retire       = mem_ready && is_store_s;
      end
      WB:      begin rf_we = 1'b1; wb_sel_mdr = (opcode == OP_LOAD); retire = 1'b1; end
      TRAP:    trap = 1'b1;
      default: trap = 1'b1;
    endcase
  end
endmodule

// File: rtl/reg_file.sv
// Two-read, one-write register file; x0 is never written and so always reads zero.
module reg_file #(
  parameter int DW         = 32,
  parameter int NO_OF_REGS = 32,
  parameter int REGW       = $clog2(NO_OF_REGS)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we,
  input  logic [REGW-1:0] waddr,
  input  logic [DW-1:0]   wdata,
  input  logic [REGW-1:0] raddr1,
  input  logic [REGW-1:0] raddr2,
  output logic [DW-1:0]   rdata1,
  output logic [DW-1:0]   rdata2
);
  logic [DW-1:0] regs [NO_OF_REGS];

  // storage with clear-on-reset
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NO_OF_REGS; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];
endmodule

// File: rtl/riscv_mc_core.sv
// Multi-cycle RV32I-subset core: datapath registers and muxes around the controller,
// with one unified req/ready memory port for fetch and load/store.
module riscv_mc_core import riscv_pkg::*; #(
  parameter int            DW         = 32,
  parameter int            NO_OF_REGS = 32,
  parameter int            REGW       = $clog2(NO_OF_REGS),
  parameter logic [DW-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [DW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ready_i,
  output logic          retire_o,
  output logic          trap_o
);
  localparam logic [DW-1:0] FOUR = DW'(4);

  logic [DW-1:0] pc_r, old_pc_r, ir_r, a_r, b_r, alu_out_r, mdr_r;
  logic [DW-1:0] rs1_data_s, rs2_data_s, imm_s, alu_y_s, rf_wdata_s;
  logic mem_req_s, mem_we_s, addr_sel_alu_s, ir_en_s, ab_en_s, pc_target_en_s, mdr_en_s;
  logic rf_we_s, wb_sel_mdr_s, src_b_imm_s;
  aluout_sel_e aluout_sel_s;
  imm_src_e    imm_src_s;
  alu_op_e     alu_op_s;

  mc_controller u_ctrl (
    .clk_i(clk_i), .rst_i(rst_i),
    .opcode(ir_r[6:0]), .f3(ir_r[14:12]), .f7b5(ir_r[30]),
    .mem_ready(mem_ready_i),
    .addr_misaligned(alu_y_s[1:0] != 2'b00),
    .target_misaligned(alu_out_r[1:0] != 2'b00),
    .operands_equal(a_r == b_r),
    .mem_req(mem_req_s), .mem_we(mem_we_s), .addr_sel_alu(addr_sel_alu_s),
    .ir_en(ir_en_s), .ab_en(ab_en_s), .pc_target_en(pc_target_en_s), .mdr_en(mdr_en_s),
    .rf_we(rf_we_s), .wb_sel_mdr(wb_sel_mdr_s), .src_b_imm(src_b_imm_s),
    .aluout_sel(aluout_sel_s), .imm_src(imm_src_s), .alu_op(alu_op_s),
    .retire(retire_o), .trap(trap_o)
  );

  reg_file #(.DW(DW), .NO_OF_REGS(NO_OF_REGS), .REGW(REGW)) u_rf (
    .clk_i(clk_i), .rst_i(rst_i), .we(rf_we_s), .waddr(ir_r[7 +: REGW]), .wdata(rf_wdata_s),
    .raddr1(ir_r[15 +: REGW]), .raddr2(ir_r[20 +: REGW]), .rdata1(rs1_data_s), .rdata2(rs2_data_s)
  );

  imm_generator #(.DW(DW)) u_imm (.instr(ir_r[31:7]), .imm_src(imm_src_s), .imm(imm_s));

  alu #(.DW(DW)) u_alu (.a(a_r), .b(src_b_imm_s ? imm_s : b_r), .op(alu_op_s), .y(alu_y_s));

  assign rf_wdata_s = wb_sel_mdr_s ? mdr_r : alu_out_r;

  // reset must drop a pending request at once, before the FSM has a clock to react
  assign mem_req_o   = mem_req_s & rst_i;
  assign mem_we_o    = mem_we_s & rst_i;
  assign mem_addr_o  = addr_sel_alu_s ? alu_out_r : pc_r;
  assign mem_wdata_o = b_r;

  // datapath registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_r <= RESET_PC; old_pc_r <= '0; ir_r <= '0; a_r <= '0; b_r <= '0;
      alu_out_r <= '0; mdr_r <= '0;
    end else begin
      if (ir_en_s) begin
        ir_r     <= mem_rdata_i;
        old_pc_r <= pc_r;
        pc_r     <= pc_r + FOUR;
      end else if (pc_target_en_s) begin
        pc_r <= alu_out_r;
      end
      if (ab_en_s) begin
        a_r <= rs1_data_s;
        b_r <= rs2_data_s;
      end
      case (aluout_sel_s)
        AO_TARGET: alu_out_r <= old_pc_r + imm_s;
        AO_ALU:    alu_out_r <= alu_y_s;
        AO_LINK:   alu_out_r <= old_pc_r + FOUR;
        AO_IMM:    alu_out_r <= imm_s;
        default:   alu_out_r <= alu_out_r;
      endcase
      if (mdr_en_s) mdr_r <= mem_rdata_i;
    end
  end
endmodule

// File: tb/tb_riscv_mc_core.sv
// Scoreboard bench for riscv_mc_core: a wait-state memory model, expected transactions
// and retire cycles queued per program, and a monitor comparing at every handshake.
module tb_riscv_mc_core;
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req_o, mem_we_o, mem_ready_i, retire_o, trap_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  logic [31:0] mem [64];
  txn_t        exp_q [$];
  int          ret_q [$];
  int          checks = 0;
  int          errors = 0;
  int          waits = 0;
  int          wcnt = 0;
  int          cnt = 0;
  int          exp_trap = 0;

  riscv_mc_core u_dut (
    .clk_i(clk), .rst_i(rst_n), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .mem_ready_i(mem_ready_i), .retire_o(retire_o), .trap_o(trap_o)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_f(input logic [31:0] a);
    exp_q.push_back('{we: 1'b0, addr: a, wdata: 32'h0});
  endtask
  task automatic push_s(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back('{we: 1'b1, addr: a, wdata: d});
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
  endtask

  // addi/add, sw/lw round trip, then a misaligned lw
  task automatic load_prog_a();
    clear_mem();
    mem[0] = 32'h00500093;  // addi x1,x0,5
    mem[1] = 32'h00108133;  // add  x2,x1,x1
    mem[2] = 32'h00202423;  // sw   x2,8(x0)
    mem[3] = 32'h00802183;  // lw   x3,8(x0)
    mem[4] = 32'h04302023;  // sw   x3,64(x0)
    mem[5] = 32'h00202083;  // lw   x1,2(x0)  misaligned
  endtask

  // x0 write, branches, jal, then an illegal opcode
  task automatic load_prog_b();
    clear_mem();
    mem[0]  = 32'h00700013; // addi x0,x0,7
    mem[1]  = 32'h04002023; // sw   x0,64(x0)
    mem[2]  = 32'h00000663; // 0x08 beq x0,x0,+12 -> 0x14
    mem[5]  = 32'h00001663; // 0x14 bne x0,x0,+12 -> falls to 0x18
    mem[6]  = 32'h00000C63; // 0x18 beq x0,x0,+24 -> 0x30
    mem[8]  = 32'h04502223; // 0x20 sw   x5,68(x0)
    mem[9]  = 32'h0000007F; // 0x24 illegal
    mem[12] = 32'hFF1FF2EF; // 0x30 jal  x5,-16 -> 0x20
  endtask

  task automatic push_prog_a_txns();
    push_f(32'h00); push_f(32'h04); push_f(32'h08); push_s(32'h08, 32'd10);
    push_f(32'h0C); push_f(32'h08); push_f(32'h10); push_s(32'h40, 32'd10); push_f(32'h14);
  endtask

  task automatic check_reset_outputs();
    check("rst_req", {31'd0, mem_req_o}, 32'd0);
    check("rst_we", {31'd0, mem_we_o}, 32'd0);
    check("rst_retire", {31'd0, retire_o}, 32'd0);
    check("rst_trap", {31'd0, trap_o}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk); #4;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    exp_trap = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_release();
    @(negedge clk); #4;
    rst_n = 1'b1;
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_txn_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_retire_left"}, 32'(ret_q.size()), 32'd0);
  endtask

  // cycle counter: 0 until the first edge after reset release
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) cnt = 0;
      else cnt++;
    end
  end

  // memory model: ready after `waits` stall cycles, stores land when ready is given
  initial begin
    mem_ready_i = 1'b0;
    mem_rdata_i = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk or posedge rst_n);
      #1;
      mem_rdata_i = 32'hDEAD_BEEF;
      if (!rst_n) begin
        mem_ready_i = 1'b0; wcnt = 0;
      end else if (mem_req_o) begin
        if (wcnt >= waits) begin
          mem_ready_i = 1'b1; wcnt = 0;
          if (mem_we_o) mem[mem_addr_o[7:2]] = mem_wdata_o;
          mem_rdata_i = mem[mem_addr_o[7:2]];
        end else begin
          mem_ready_i = 1'b0; wcnt++;
        end
      end else begin
        mem_ready_i = 1'b0; wcnt = 0;
      end
    end
  end

  // monitor: handshakes, hold stability, retire timing and trap behaviour
  initial begin
    logic        prev_wait;
    logic [31:0] prev_addr, prev_wdata;
    logic        prev_we;
    int          cyc;
    txn_t        t;
    prev_wait = 1'b0; prev_addr = '0; prev_wdata = '0; prev_we = 1'b0;
    forever begin
      @(negedge clk or posedge rst_n);
      #2;
      if (!rst_n) begin
        prev_wait = 1'b0;
      end else begin
        cyc = cnt + 1;
        if (prev_wait) begin
          check("hold_req", {31'd0, mem_req_o}, 32'd1);
          check("hold_addr", mem_addr_o, prev_addr);
          check("hold_we", {31'd0, mem_we_o}, {31'd0, prev_we});
          if (prev_we) check("hold_wdata", mem_wdata_o, prev_wdata);
        end
        if (mem_req_o && mem_ready_i) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL txn_unexpected: got addr %h we %0d expected no transfer", mem_addr_o, mem_we_o);
          end else begin
            t = exp_q.pop_front();
            check("txn_addr", mem_addr_o, t.addr);
            check("txn_we", {31'd0, mem_we_o}, {31'd0, t.we});
            if (t.we) check("txn_wdata", mem_wdata_o, t.wdata);
          end
        end
        prev_wait  = mem_req_o && !mem_ready_i;
        prev_addr  = mem_addr_o;
        prev_we    = mem_we_o;
        prev_wdata = mem_wdata_o;
        if (retire_o) begin
          if (ret_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL retire_unexpected: got retire at cycle %0d expected none", cyc);
          end else begin
            check("retire_cycle", 32'(cyc), 32'(ret_q.pop_front()));
          end
        end
        if (exp_trap != 0) begin
          if (cyc == exp_trap - 1) check("trap_early", {31'd0, trap_o}, 32'd0);
          else if (cyc >= exp_trap) check("trap_set", {31'd0, trap_o}, 32'd1);
        end
        if (trap_o) check("trap_no_req", {31'd0, mem_req_o}, 32'd0);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #4;
    check_reset_outputs();

    // zero-wait run of program A
    load_prog_a();
    waits = 0;
    push_prog_a_txns();
    ret_q = '{4, 8, 12, 17, 21};
    exp_trap = 25;
    do_release();
    repeat (30) @(negedge clk);
    check_drained("a0");
    check("a0_x1_kept", u_dut.u_rf.regs[1], 32'd5);

    // same program with two wait cycles on every access
    do_reset();
    load_prog_a();
    waits = 2;
    push_prog_a_txns();
    ret_q = '{6, 12, 20, 29, 37};
    exp_trap = 43;
    do_release();
    repeat (50) @(negedge clk);
    check_drained("a2");
    check("a2_x1_kept", u_dut.u_rf.regs[1], 32'd5);

    // reset dropped into a stalled fetch
    do_reset();
    load_prog_b();
    waits = 5;
    do_release();
    repeat (3) @(negedge clk);
    #4;
    check("stall_req_up", {31'd0, mem_req_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_req_drop", {31'd0, mem_req_o}, 32'd0);
    check_reset_outputs();
    repeat (2) @(negedge clk);

    // zero-wait run of program B
    waits = 0;
    push_f(32'h00); push_f(32'h04); push_s(32'h40, 32'h0); push_f(32'h08); push_f(32'h14);
    push_f(32'h18); push_f(32'h30); push_f(32'h20); push_s(32'h44, 32'h34); push_f(32'h24);
    ret_q = '{4, 8, 11, 14, 17, 21, 25};
    exp_trap = 28;
    do_release();
    repeat (35) @(negedge clk);
    check_drained("b0");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
